spi_slave_reg_ctrl: RTL

SPI_SLAVE_REG_CTRL -- requirements
Module: spi_slave_reg_ctrl

---
 rtl/spi_pkg.sv | 18 +
 rtl/sync_2ff.sv | 26 ++
 rtl/spi_slave_reg_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-access controller: FSM states,
// command-byte bit positions and the register address width.
package spi_pkg;

    localparam int REG_ADDR_W = 6;
    localparam int RW_BIT     = 7;
    localparam int INC_BIT    = 6;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_DATA,
        RD_REQ,
        RD_WAIT,
        RD_DATA
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous control bit.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic stage1_q;
    logic stage2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage1_q <= RESET_VAL;
            stage2_q <= RESET_VAL;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/spi_slave_reg_ctrl.sv
// Turns the byte stream of a byte-level SPI slave into register-bus reads and
// writes: one command byte (rw, inc, address) followed by data bytes.
module spi_slave_reg_ctrl
    import spi_pkg::*;
#(
    parameter logic [7:0] DUMMY_BYTE = 8'hA5,
    parameter int         TXN_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  spi_cs,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    output logic [7:0]            tx_byte,
    output logic                  spi_en,
    output logic [REG_ADDR_W-1:0] reg_addr,
    output logic [7:0]            reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [7:0]            reg_rdata,
    output logic                  busy,
    output logic                  txn_done,
    output logic [TXN_CNT_W-1:0]  txn_bytes
);

    logic                  csSync;
    logic                  csPrev_q;
    logic                  csStart;
    logic                  csEnd;
    state_e                state_q, state_d;
    logic [REG_ADDR_W-1:0] curAddr_q, curAddr_d;
    logic [REG_ADDR_W-1:0] nextAddr;
    logic                  incMode_q, incMode_d;
    logic [TXN_CNT_W-1:0]  byteCnt_q, byteCnt_d;
    logic [TXN_CNT_W-1:0]  cntSat;
    logic [7:0]            txByte_q, txByte_d;
    logic [REG_ADDR_W-1:0] regAddr_q, regAddr_d;
    logic [7:0]            regWdata_q, regWdata_d;
    logic                  regWe_q, regWe_d;
    logic                  regRe_q, regRe_d;
    logic                  txnDone_q, txnDone_d;
    logic [TXN_CNT_W-1:0]  txnBytes_q, txnBytes_d;
    logic                  spiEn_q;

    sync_2ff #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk (clk),
        .rst (rst),
        .d_i (spi_cs),
        .q_o (csSync)
    );

    assign csStart  = csPrev_q & ~csSync;
    assign csEnd    = ~csPrev_q & csSync;
    assign nextAddr = curAddr_q + REG_ADDR_W'(incMode_q);
    assign cntSat   = (&byteCnt_q) ? byteCnt_q : byteCnt_q + TXN_CNT_W'(1);

    // Strobes are registered one state ahead, so reg_re is high exactly while
    // the FSM sits in RD_REQ and read data can be captured in RD_WAIT.
    always_comb begin
        state_d    = state_q;
        curAddr_d  = curAddr_q;
        incMode_d  = incMode_q;
        byteCnt_d  = byteCnt_q;
        txByte_d   = txByte_q;
        regAddr_d  = regAddr_q;
        regWdata_d = regWdata_q;
        regWe_d    = 1'b0;
        regRe_d    = 1'b0;
        txnDone_d  = 1'b0;
        txnBytes_d = txnBytes_q;

        if (state_q != IDLE && rx_valid) begin
            byteCnt_d = cntSat;
        end

        case (state_q)
            IDLE: begin
                if (csStart && enable) begin
                    state_d   = CMD;
                    txByte_d  = DUMMY_BYTE;
                    byteCnt_d = '0;
                end
            end
            CMD: begin
                if (rx_valid) begin
                    curAddr_d = rx_byte[REG_ADDR_W-1:0];
                    incMode_d = rx_byte[INC_BIT];
                    if (rx_byte[RW_BIT]) begin
                        state_d   = RD_REQ;
                        regRe_d   = 1'b1;
                        regAddr_d = rx_byte[REG_ADDR_W-1:0];
                    end else begin
                        state_d = WR_DATA;
                    end
                end
            end
            WR_DATA: begin
                if (rx_valid) begin
                    regWe_d    = 1'b1;
                    regWdata_d = rx_byte;
                    regAddr_d  = curAddr_q;
                    curAddr_d  = nextAddr;
                end
            end
            RD_REQ: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                txByte_d = reg_rdata;
                state_d  = RD_DATA;
            end
            RD_DATA: begin
                if (rx_valid) begin
                    curAddr_d = nextAddr;
                    regAddr_d = nextAddr;
                    regRe_d   = 1'b1;
                    state_d   = RD_REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A byte arriving with CS rise still counts and still writes, but no new read starts.
        if (state_q != IDLE && (csEnd || !enable)) begin
            state_d    = IDLE;
            regRe_d    = 1'b0;
            txnDone_d  = 1'b1;
            txnBytes_d = byteCnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csPrev_q   <= 1'b1;
            state_q    <= IDLE;
            curAddr_q  <= '0;
            incMode_q  <= 1'b0;
            byteCnt_q  <= '0;
            txByte_q   <= DUMMY_BYTE;
            regAddr_q  <= '0;
            regWdata_q <= '0;
            regWe_q    <= 1'b0;
            regRe_q    <= 1'b0;
            txnDone_q  <= 1'b0;
            txnBytes_q <= '0;
            spiEn_q    <= 1'b0;
        end else begin
            csPrev_q   <= csSync;
            state_q    <= state_d;
            curAddr_q  <= curAddr_d;
            incMode_q  <= incMode_d;
            byteCnt_q  <= byteCnt_d;
            txByte_q   <= txByte_d;
            regAddr_q  <= regAddr_d;
            regWdata_q <= regWdata_d;
            regWe_q    <= regWe_d;
            regRe_q    <= regRe_d;
            txnDone_q  <= txnDone_d;
            txnBytes_q <= txnBytes_d;
            spiEn_q    <= enable;
        end
    end

    assign tx_byte   = txByte_q;
    assign spi_en    = spiEn_q;
    assign reg_addr  = regAddr_q;
    assign reg_wdata = regWdata_q;
    assign reg_we    = regWe_q;
    assign reg_re    = regRe_q;
    assign busy      = (state_q != IDLE);
    assign txn_done  = txnDone_q;
    assign txn_bytes = txnBytes_q;

endmodule
